// File: rtl/stall_arb_2.sv
// stall_arb_2: round-robin arbiter giving two four-phase bundled-data clients one shared stall channel; define STALL_ARB_TIMEOUT_EN for a sticky ack-timeout err_out
module stall_arb_2 #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_a_in,
  input  logic [2:0] data_a_in,
  output logic       ack_a_out,
  input  logic       req_b_in,
  input  logic [2:0] data_b_in,
  output logic       ack_b_out,
  output logic       req_out,
  output logic [2:0] data_out,
  input  logic       ack_in,
  output logic [1:0] grant_out,
  output logic       err_out
);
  typedef enum logic [1:0] {IDLE, REQ, ACK, REL} state_t;
  state_t state, state_n;
  logic [1:0] req_a_q, req_b_q, ack_q, grant_n;
  logic [2:0] data_n;
  logic prio, prio_n, req_n, ack_a_n, ack_b_n;
  logic req_a_s, req_b_s, ack_s, pick_b, own_req;
  assign req_a_s = req_a_q[1];
  assign req_b_s = req_b_q[1];
  assign ack_s = ack_q[1];
  assign pick_b = req_b_s && (!req_a_s || prio);
  assign own_req = grant_out[1] ? req_b_s : req_a_s;
  always_comb begin
    state_n = state;
    prio_n = prio;
    req_n = req_out;
    ack_a_n = ack_a_out;
    ack_b_n = ack_b_out;
    grant_n = grant_out;
    data_n = data_out;
    case (state)
      IDLE: if (req_a_s || req_b_s) begin
        state_n = REQ;
        req_n = 1'b1;
        grant_n = pick_b ? 2'b10 : 2'b01;
        data_n = pick_b ? data_b_in : data_a_in;
      end
      REQ: if (ack_s) begin
        state_n = ACK;
        ack_a_n = grant_out[0];
        ack_b_n = grant_out[1];
      end
      ACK: if (!own_req) begin
        state_n = REL;
        req_n = 1'b0;
      end
      REL: if (!ack_s) begin
        state_n = IDLE;
        ack_a_n = 1'b0;
        ack_b_n = 1'b0;
        grant_n = 2'b00;
        prio_n = !prio;
      end
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      req_a_q <= '0;
      req_b_q <= '0;
      ack_q <= '0;
      state <= IDLE;
      prio <= 1'b0;
      req_out <= 1'b0;
      ack_a_out <= 1'b0;
      ack_b_out <= 1'b0;
      grant_out <= '0;
      data_out <= '0;
    end else begin
      req_a_q <= {req_a_q[0], req_a_in};
      req_b_q <= {req_b_q[0], req_b_in};
      ack_q <= {ack_q[0], ack_in};
      state <= state_n;
      prio <= prio_n;
      req_out <= req_n;
      ack_a_out <= ack_a_n;
      ack_b_out <= ack_b_n;
      grant_out <= grant_n;
      data_out <= data_n;
    end
`ifdef STALL_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt, cnt_n;
  logic wait_n;
  assign wait_n = state_n == REQ || state_n == REL;
  assign cnt_n = state_n != state ? '0 : (wait_n && cnt != CW'(TIMEOUT_CYCLES)) ? cnt + CW'(1) : cnt;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      cnt <= '0;
      err_out <= 1'b0;
    end else begin
      cnt <= cnt_n;
      err_out <= err_out || cnt_n == CW'(TIMEOUT_CYCLES);
    end
`else
  assign err_out = TIMEOUT_CYCLES < 1;
`endif
endmodule

// File: doc/stall_arb_2.md
# stall_arb_2

Two-client arbiter for a shared bundled-data stall channel. Two four-phase requesters (A, B), each carrying 3-bit data, compete for one downstream req/ack/data channel that feeds a stall stage. The arbiter synchronizes the asynchronous handshake inputs, grants one client at a time with round-robin fairness, and sequences the full four-phase cycle on both sides. It sits between the client pipelines and the stall stage.

## Interface
- TIMEOUT_CYCLES, 64: cycles allowed in REQ or REL waiting on downstream ack before err_out is set (only with the macro enabled); must be ≥1.
- clk  in  1  rising-edge clock
- rst  in  1  reset, asynchronous, active-high
- req_a_in  in  1  client A request (four-phase, asynchronous)
- data_a_in  in  3  client A data, stable while req_a_in high
- ack_a_out  out  1  client A acknowledge
- req_b_in  in  1  client B request
- data_b_in  in  3  client B data
- ack_b_out  out  1  client B acknowledge
- req_out  out  1  request to stall stage
- data_out  out  3  data to stall stage, registered
- ack_in  in  1  acknowledge from stall stage (asynchronous)
- grant_out  out  2  one-hot owner: 01=A, 10=B, 00=none
- err_out  out  1  sticky handshake-timeout flag

## Operation
- req_a_in, req_b_in and ack_in each pass through a 2-flop synchronizer (req_a_s, req_b_s, ack_s). Data inputs are not synchronized. Bundled-data rule: data is stable before and while req is high.
- Priority pointer prio: reset = A. It toggles to the other client when a transaction returns to IDLE.
- FSM states: IDLE, REQ, ACK, REL.
  - IDLE: if only one req_x_s is high, grant that client. If both are high, grant the client selected by prio. On grant: latch data_x_in into data_out, set req_out=1, set grant_out, go to REQ.
  - REQ: req_out=1. When ack_s=1, set ack_x_out=1 for the granted client and go to ACK.
  - ACK: when the granted req_x_s=0, set req_out=0 and go to REL.
  - REL: when ack_s=0, set ack_x_out=0 and grant_out=00, toggle prio, go to IDLE.
- The non-granted client's request is held pending. It is never dropped and never acknowledged out of turn.
- data_out holds its last value after a transaction ends. It changes only at a grant.
- Reset, asynchronous and at any time including mid-handshake: state=IDLE, req_out=0, ack_a_out=0, ack_b_out=0, data_out=000, grant_out=00, err_out=0, prio=A, all synchronizer flops=0, timeout counter=0.

## Timing
- Edge numbering: edge 0 is the first rising edge that samples the input high.
- Request path: req_x_in first sampled high at edge 0 → req_x_s high after edge 1 → req_out, data_out and grant_out valid after edge 2. Grant latency is 3 edges.
- ack_in rising sampled at edge j → ack_x_out high after edge j+2.
- req_x_in falling sampled at edge k → req_out low after edge k+2.
- ack_in falling sampled at edge m → ack_x_out low, grant_out=00 after edge m+2. The state is IDLE from that edge.
- A pending opposite request (already synchronized) is granted at the edge after the return to IDLE, giving back-to-back turnover of 1 idle cycle.
- Both requests first synchronized on the same edge → the prio client wins, with no extra cycle.
- All outputs are registered. No combinational path from any input to any output.

## Configuration
- STALL_ARB_TIMEOUT_EN defined:
  - A counter of width $clog2(TIMEOUT_CYCLES+1) clears on entry to REQ and REL and increments each cycle spent in those states. It saturates.
  - When the counter reaches TIMEOUT_CYCLES, err_out is set to 1 and stays 1 until rst.
  - The FSM keeps waiting; the handshake is not aborted.
- STALL_ARB_TIMEOUT_EN undefined: no counter; err_out is constant 0.

## Test plan
- Single client A: reset, req_a_in=1 with data_a_in=101, stall stage echoes ack after 3 cycles → req_out high 3 edges after req, data_out=101, grant_out=01, ack_a_out rises 2 edges after ack_in, full four-phase completes, prio=B afterwards.
- Simultaneous A and B from reset (data 011/110) → A served first with data_out=011, then B with data_out=110 after 1 idle cycle. ack_b_out stays 0 throughout A's transaction.
- Fairness: A and B held continuously requesting for 4 transactions → grant order A, B, A, B.
- Reset asserted while in ACK (req_out=1, ack_a_out=1) → all outputs 0 immediately, without waiting for clk. After release, a fresh request is granted normally.
- With STALL_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=8, ack_in held 0 → err_out=1 after 8 cycles in REQ and stays 1 after ack_in later completes the transaction. Without the macro, err_out stays 0 under the same stimulus.
- data_a_in changed after grant while req_a_in still high → data_out keeps the value latched at grant.
